// File: rtl/side_sched_pkg.sv
// rtl/side_sched_pkg.sv - shared sizes and one-hot/binary helpers for side_sched
package side_sched_pkg;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  // One-hot (or zero) vector to binary index; zero input maps to index 0.
  function automatic logic [AW-1:0] oh2bin(input logic [N-1:0] oh);
    logic [AW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | AW'(i);
    end
    return b;
  endfunction

  // Binary index to one-hot vector.
  function automatic logic [N-1:0] bin2oh(input logic [AW-1:0] b);
    return N'(1) << b;
  endfunction

endpackage

// File: rtl/side_sched_rr_pick.sv
// rtl/side_sched_rr_pick.sv - combinational N-way round-robin picker
module rr_pick
  import side_sched_pkg::*;
(
  input  logic [N-1:0]  elig,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [AW-1:0] idx,
  output logic          any
);

  logic [AW-1:0] p;

  // Scan from farthest to nearest so the first eligible port at or after ptr wins.
  always_comb begin
    gnt = '0;
    p   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = ptr + AW'(k);
      if (elig[p]) gnt = bin2oh(p);
    end
  end

  assign idx = oh2bin(gnt);
  assign any = |gnt;

endmodule

// File: rtl/side_sched.sv
// rtl/side_sched.sv - credit-based round-robin scheduler for the shared internal bus
module side_sched
  import side_sched_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic [N*AW-1:0] dst_i,
  input  logic [N-1:0]    crd_ret_i,
  output logic [N-1:0]    gnt_o,
  output logic [AW-1:0]   sel_o,
  output logic            sel_vld_o,
  output logic [N-1:0]    wen_o,
  output logic [N*CW-1:0] crd_o,
  output logic            err_o
);

  logic [CW-1:0] crd [N];
  logic [AW-1:0] ptr;
  logic [N-1:0]  elig;
  logic [N-1:0]  pick_gnt;
  logic [AW-1:0] pick_idx;
  logic          pick_any;
  logic          gnt_any;
  logic [AW-1:0] gnt_dst;
  logic [N-1:0]  cons;

  logic          s1_vld;
  logic [AW-1:0] s1_idx;
  logic [AW-1:0] s1_dst;
  logic          s2_vld;
  logic [AW-1:0] s2_dst;

  // A port is eligible when it has a word and its destination has a free slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req_i[i] && (crd[dst_i[i*AW +: AW]] != '0);
    end
  end

  rr_pick u_pick (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Grants are suppressed while reset is held so no port pops a word.
  assign gnt_o   = rst_i ? pick_gnt : '0;
  assign gnt_any = rst_i & pick_any;
  assign gnt_dst = dst_i[pick_idx*AW +: AW];
  assign cons    = gnt_any ? bin2oh(gnt_dst) : '0;

  // Per-destination slot accounting; simultaneous consume and return cancel out.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int j = 0; j < N; j++) crd[j] <= CW'(DEPTH);
      err_o <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        case ({cons[j], crd_ret_i[j]})
          2'b10: crd[j] <= crd[j] - 1'b1;
          2'b01: begin
            if (crd[j] == CW'(DEPTH)) err_o <= 1'b1;
            else                      crd[j] <= crd[j] + 1'b1;
          end
          default: crd[j] <= crd[j];
        endcase
      end
    end
  end

  // Round-robin pointer moves just past the granted port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       ptr <= '0;
    else if (gnt_any) ptr <= pick_idx + 1'b1;
  end

  // Two-stage steering pipeline: mux select at t+1, FIFO write enable at t+2.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
      s1_dst <= '0;
      s2_vld <= 1'b0;
      s2_dst <= '0;
    end else begin
      s1_vld <= gnt_any;
      if (gnt_any) begin
        s1_idx <= pick_idx;
        s1_dst <= gnt_dst;
      end
      s2_vld <= s1_vld;
      s2_dst <= s1_dst;
    end
  end

  assign sel_o     = s1_idx;
  assign sel_vld_o = s1_vld;
  assign wen_o     = s2_vld ? bin2oh(s2_dst) : '0;

  // Flatten credit counters for debug visibility.
  always_comb begin
    crd_o = '0;
    for (int j = 0; j < N; j++) crd_o[j*CW +: CW] = crd[j];
  end

endmodule

// File: doc/side_sched.md
# side_sched

Credit-based round-robin scheduler for the switch side's shared internal bus. Decides each cycle which of N ingress ports may move one word to its addressed egress FIFO. Grants only when that destination has a free slot. Emits the pipelined mux select and one-hot write enable that steer the shared data path. Replaces the full-flag-gated arbiter path with exact per-destination slot accounting.

## Interface
- N, 4, number of ingress ports and egress FIFOs (power of two).
- AW, 2, log2(N), destination address width.
- DEPTH, 2, egress FIFO depth; initial and maximum credit per destination.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  N  port i has a head word ready.
- dst_i  in  N*AW  destination of port i head word; bits [i*AW +: AW].
- crd_ret_i  in  N  one-cycle pulse: egress FIFO j popped one word, returning one credit.
- gnt_o  out  N  one-hot or zero; port i pops its head word this cycle.
- sel_o  out  AW  binary index of the port granted one cycle earlier (data mux select).
- sel_vld_o  out  1  sel_o is valid.
- wen_o  out  N  one-hot write enable to egress FIFO, two cycles after the grant.
- crd_o  out  N*CW  current credit count per destination, for debug.
- err_o  out  1  sticky flag: credit return while the credit count is already DEPTH.

## Operation
- Credit counters crd[j] have width CW = clog2(DEPTH+1) and reset to DEPTH.
- Port i is eligible when req_i[i]=1 and crd[dst_i[i]] > 0.
- Round-robin pointer ptr (AW bits) resets to 0. The search starts at ptr and wraps modulo N; the first eligible port wins.
- When port i is granted, ptr becomes (i+1) mod N at the clock edge. With no grant, ptr holds.
- gnt_o is a combinational function of req_i, dst_i, crd and ptr. At most one grant per cycle; back-to-back grants are allowed.
- Grant to port i for destination j: crd[j] decrements by 1 at the edge.
- crd_ret_i[j]=1: crd[j] increments by 1 at the edge.
  - Consume and return on the same j in the same cycle: net change 0. This holds even when crd[j] = 0 or crd[j] = DEPTH.
  - Return alone with crd[j] = DEPTH: crd[j] saturates at DEPTH and err_o sets. err_o clears only on reset.
- Pipeline stage 1 registers {vld, idx=i, dst=j} at the grant edge. It drives sel_o/sel_vld_o.
- Pipeline stage 2 registers stage 1. It drives wen_o = onehot(dst) when vld, else 0.
- No request, or all requests blocked on zero credit: gnt_o = 0 and no pipeline bubble is tracked beyond vld=0.
- A blocked port does not block other eligible ports. The round-robin order skips it.

## Timing
- Grant in cycle t.
  - t: gnt_o.
  - t+1: sel_o/sel_vld_o (port data is latched by the mux register during t+1).
  - t+2: wen_o, aligned with the registered data word.
- Credit visible in the eligibility check one cycle after consumption or return (t+1).
- Reset values: gnt_o=0 (no credits are needed, but ptr=0 and all regs are cleared; gnt_o follows req_i once rst_i deasserts), sel_o=0, sel_vld_o=0, wen_o=0, crd=DEPTH for every destination, err_o=0, ptr=0.
- Reset asserted mid-operation: in-flight pipeline entries are discarded and no wen_o is issued. Egress FIFOs share rst_i, so restoring credits to DEPTH is consistent.
- gnt_o must be forced to 0 while rst_i=0.

## Structure
- Shared package holds:
  - N, AW, DEPTH defaults and CW.
  - A onehot-to-binary function (also used for sel_o).
  - A binary-to-onehot function (used for wen_o).
- One sub-module, `rr_pick`: combinational N-way round-robin picker. Inputs: eligible vector and ptr. Outputs: one-hot grant and binary index.
- Credit counters, pointer and the two pipeline stages live in side_sched.

## Test plan
- Single request, port 2 to destination 1, after reset:
  - gnt_o=4'b0100 at t.
  - sel_o=2, sel_vld_o=1 at t+1.
  - wen_o=4'b0010 at t+2.
  - crd[1]=1 at t+1.
- All four ports requesting distinct destinations continuously, no returns: grants go 0,1,2,3,0,1,2,3. Each destination then reaches 0 credit and grants stop after 8.
- Ports 0 and 1 both target destination 3 with DEPTH=2: exactly two grants. Further requests stay ungranted until crd_ret_i[3] pulses, then exactly one more grant.
- Port 0 blocked (destination 0 at 0 credit) while port 1 targets destination 2: port 1 is granted every cycle; port 0 never is.
- Same-cycle grant to destination 2 with crd_ret_i[2]=1 and crd[2]=2: crd[2] stays 2, err_o stays 0. A lone return at crd=2 sets err_o=1, crd stays 2.
- rst_i pulsed low at t+1 after a grant at t: wen_o stays 0 and all credits read DEPTH. Pointer restarts at 0, and the first grant after release goes to the lowest-indexed requester.
